ysyx_22040386_idex_stage: RTL and testbench

YSYX_22040386_IDEX_STAGE -- requirements
Module: ysyx_22040386_idex_stage

---
 rtl/ysyx_22040386_pkg.sv | 33 +++
 rtl/ysyx_22040386_pipe_reg.sv | 29 ++
 rtl/ysyx_22040386_idex_stage.sv | 145 ++++++++++++++
 tb/tb_ysyx_22040386_idex_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_pkg.sv
// Shared widths, payload layout and state encoding for the ID/EX stage.
package ysyx_22040386_pkg;

    localparam int XLEN      = 64;
    localparam int ALUCTR_W  = 5;
    localparam int REG_W     = 5;
    // pc + src1 + src2 + aluctr + word_op + rd + rf_wen = 204 bits
    localparam int PAYLOAD_W = 3 * XLEN + ALUCTR_W + 1 + REG_W + 1;

    // Buffer occupancy: EMPTY = no entries, ONE = main only, TWO = main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Everything that travels from decode to execute, carried bit-exact.
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     src1;
        logic [XLEN-1:0]     src2;
        logic [ALUCTR_W-1:0] aluctr;
        logic                word_op;
        logic [REG_W-1:0]    rd;
        logic                rf_wen;
    } payload_t;

    // Next-state occupancy decode, shared by the handshake flags.
    function automatic logic state_full(input state_e st);
        return (st == TWO);
    endfunction

endpackage

// File: rtl/ysyx_22040386_pipe_reg.sv
// Payload-wide register with asynchronous reset to zero and a load enable.
module ysyx_22040386_pipe_reg
    import ysyx_22040386_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Load d when enabled, otherwise hold; clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ysyx_22040386_idex_stage.sv
// ID/EX pipeline stage: two-entry skid buffer (main drives the outputs,
// skid absorbs one extra instruction so in_ready never depends on out_ready).
module ysyx_22040386_idex_stage
    import ysyx_22040386_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_src1,
    input  logic [XLEN-1:0]     in_src2,
    input  logic [ALUCTR_W-1:0] in_aluctr,
    input  logic                in_word_op,
    input  logic [REG_W-1:0]    in_rd,
    input  logic                in_rf_wen,

    input  logic                flush,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2,
    output logic [ALUCTR_W-1:0] out_aluctr,
    output logic                out_word_op,
    output logic [REG_W-1:0]    out_rd,
    output logic                out_rf_wen
);

    state_e   state_r;
    state_e   next_state_s;
    logic     in_ready_r;
    logic     out_valid_r;

    logic     in_fire_s;
    logic     out_fire_s;
    logic     main_en_s;
    logic     skid_en_s;
    payload_t in_payload_s;
    payload_t main_d_s;
    payload_t main_q_s;
    payload_t skid_q_s;

    assign in_payload_s = '{pc:      in_pc,
                            src1:    in_src1,
                            src2:    in_src2,
                            aluctr:  in_aluctr,
                            word_op: in_word_op,
                            rd:      in_rd,
                            rf_wen:  in_rf_wen};

    assign in_fire_s  = in_valid  & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Occupancy transitions and register load controls.
    always_comb begin
        next_state_s = state_r;
        main_en_s    = 1'b0;
        skid_en_s    = 1'b0;
        main_d_s     = in_payload_s;
        if (flush) begin
            // Everything held is dropped; a handshake on this edge counts as consumed.
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        next_state_s = ONE;
                        main_en_s    = 1'b1;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        next_state_s = TWO;
                        skid_en_s    = 1'b1;
                    end else if (!in_fire_s && out_fire_s) begin
                        next_state_s = EMPTY;
                    end else if (in_fire_s && out_fire_s) begin
                        // Consumer drained main this edge, so the new one replaces it directly.
                        next_state_s = ONE;
                        main_en_s    = 1'b1;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        next_state_s = ONE;
                        main_en_s    = 1'b1;
                        main_d_s     = skid_q_s;
                    end else begin
                        next_state_s = TWO;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // State and registered handshake flags, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= !state_full(next_state_s);
            out_valid_r <= (next_state_s != EMPTY);
        end
    end

    ysyx_22040386_pipe_reg #(.W(PAYLOAD_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en_s),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    ysyx_22040386_pipe_reg #(.W(PAYLOAD_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en_s),
        .d   (in_payload_s),
        .q   (skid_q_s)
    );

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = main_q_s.pc;
    assign out_src1    = main_q_s.src1;
    assign out_src2    = main_q_s.src2;
    assign out_aluctr  = main_q_s.aluctr;
    assign out_word_op = main_q_s.word_op;
    assign out_rd      = main_q_s.rd;
    assign out_rf_wen  = main_q_s.rf_wen;

endmodule

// File: tb/tb_ysyx_22040386_idex_stage.sv
// Scoreboard bench for the ID/EX skid-buffer stage.
module tb_ysyx_22040386_idex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_aluctr;
    logic        in_word_op;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic        flush;
    logic        out_ready;
    wire logic        in_ready;
    wire logic        out_valid;
    wire logic [63:0] out_pc;
    wire logic [63:0] out_src1;
    wire logic [63:0] out_src2;
    wire logic [4:0]  out_aluctr;
    wire logic        out_word_op;
    wire logic [4:0]  out_rd;
    wire logic        out_rf_wen;

    int checks   = 0;
    int failures = 0;
    logic [203:0] sb_q[$];

    ysyx_22040386_idex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_aluctr   (in_aluctr),
        .in_word_op  (in_word_op),
        .in_rd       (in_rd),
        .in_rf_wen   (in_rf_wen),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_src1    (out_src1),
        .out_src2    (out_src2),
        .out_aluctr  (out_aluctr),
        .out_word_op (out_word_op),
        .out_rd      (out_rd),
        .out_rf_wen  (out_rf_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [203:0] act, input logic [203:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [4:0] alu, input logic wo,
                         input logic [4:0] rd, input logic wen);
        in_valid   = v;
        in_pc      = pc;
        in_src1    = s1;
        in_src2    = s2;
        in_aluctr  = alu;
        in_word_op = wo;
        in_rd      = rd;
        in_rf_wen  = wen;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples at the falling edge what the next rising edge will transfer.
    initial begin : monitor
        logic [203:0] out_now;
        logic [203:0] in_now;
        logic [203:0] prev_out;
        logic [203:0] exp;
        logic         hold_prev;
        hold_prev = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            out_now = {out_pc, out_src1, out_src2, out_aluctr, out_word_op, out_rd, out_rf_wen};
            in_now  = {in_pc, in_src1, in_src2, in_aluctr, in_word_op, in_rd, in_rf_wen};
            if (rst) begin
                sb_q.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_valid", {203'd0, out_valid}, 204'd1);
                    check("stall_payload", out_now, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_output", out_now, 204'd0);
                        if (out_now == 204'd0) begin
                            check("unexpected_output_valid", {203'd0, out_valid}, 204'd0);
                        end
                    end else begin
                        exp = sb_q.pop_front();
                        check("sb_payload", out_now, exp);
                    end
                end
                if (flush) begin
                    sb_q.delete();
                end else if (in_valid && in_ready) begin
                    sb_q.push_back(in_now);
                end
                hold_prev = out_valid && !out_ready && !flush;
                prev_out  = out_now;
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        logic acc;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        // Reset state
        check("rst_out_valid", {203'd0, out_valid}, 204'd0);
        check("rst_in_ready", {203'd0, in_ready}, 204'd1);
        check("rst_out_pc", {140'd0, out_pc}, 204'd0);
        check("rst_out_aluctr", {199'd0, out_aluctr}, 204'd0);
        check("rst_out_rf_wen", {203'd0, out_rf_wen}, 204'd0);
        rst = 1'b0;
        tick();

        // Single pass
        out_ready = 1'b1;
        drive(1'b1, 64'h8000_0000, 64'd5, 64'd3, 5'h00, 1'b0, 5'd1, 1'b1);
        tick();
        check("single_valid", {203'd0, out_valid}, 204'd1);
        check("single_src1", {140'd0, out_src1}, 204'd5);
        check("single_src2", {140'd0, out_src2}, 204'd3);
        drive(1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFF, 5'h1F, 1'b1, 5'd31, 1'b1);
        tick();
        check("single_empty_valid", {203'd0, out_valid}, 204'd0);
        check("single_empty_ready", {203'd0, in_ready}, 204'd1);

        // Back-pressure into TWO, then drain
        out_ready = 1'b0;
        drive(1'b1, 64'h8000_0000, 64'd10, 64'd11, 5'h01, 1'b0, 5'd2, 1'b1);
        tick();
        check("bp_one_ready", {203'd0, in_ready}, 204'd1);
        drive(1'b1, 64'h8000_0004, 64'd12, 64'd13, 5'h02, 1'b1, 5'd3, 1'b0);
        tick();
        check("bp_two_ready", {203'd0, in_ready}, 204'd0);
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("bp_hold_pc", {140'd0, out_pc}, {140'd0, 64'h8000_0000});
        out_ready = 1'b1;
        tick();
        check("bp_second_pc", {140'd0, out_pc}, {140'd0, 64'h8000_0004});
        check("bp_ready_after_drain", {203'd0, in_ready}, 204'd1);
        check("bp_second_valid", {203'd0, out_valid}, 204'd1);
        tick();
        check("bp_empty", {203'd0, out_valid}, 204'd0);

        // Streaming: one per cycle, never full
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), 64'(i), 64'(i + 100), 5'(i), i[0], 5'(i + 1), ~i[0]);
            tick();
            check("stream_in_ready", {203'd0, in_ready}, 204'd1);
            check("stream_out_valid", {203'd0, out_valid}, 204'd1);
            check("stream_pc", {140'd0, out_pc}, {140'd0, 64'h1000 + 64'(4 * i)});
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("stream_end", {203'd0, out_valid}, 204'd0);

        // Flush in TWO with an input presented
        out_ready = 1'b0;
        drive(1'b1, 64'hA000, 64'd1, 64'd2, 5'h03, 1'b0, 5'd4, 1'b1);
        tick();
        drive(1'b1, 64'hA004, 64'd3, 64'd4, 5'h04, 1'b0, 5'd5, 1'b1);
        tick();
        check("flush_pre_full", {203'd0, in_ready}, 204'd0);
        flush = 1'b1;
        drive(1'b1, 64'hDEAD_0000, 64'd7, 64'd8, 5'h05, 1'b1, 5'd6, 1'b1);
        tick();
        flush = 1'b0;
        check("flush_two_valid", {203'd0, out_valid}, 204'd0);
        check("flush_two_ready", {203'd0, in_ready}, 204'd1);
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush_two_quiet", {203'd0, out_valid}, 204'd0);

        // Flush in ONE coinciding with an output handshake
        drive(1'b1, 64'hB000, 64'd9, 64'd9, 5'h06, 1'b0, 5'd7, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'hB004, 64'd9, 64'd9, 5'h07, 1'b0, 5'd8, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("flush_one_valid", {203'd0, out_valid}, 204'd0);
        tick();
        check("flush_one_quiet", {203'd0, out_valid}, 204'd0);

        // Async reset while in ONE
        out_ready = 1'b0;
        drive(1'b1, 64'hC000, 64'd1, 64'd1, 5'h08, 1'b0, 5'd9, 1'b1);
        tick();
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {203'd0, out_valid}, 204'd0);
        check("arst_pc", {140'd0, out_pc}, 204'd0);
        check("arst_ready", {203'd0, in_ready}, 204'd1);
        out_ready = 1'b1;
        drive(1'b1, 64'hC100, 64'd2, 64'd2, 5'h09, 1'b1, 5'd10, 1'b0);
        tick();
        check("arst_no_accept", {203'd0, out_valid}, 204'd0);
        rst = 1'b0;
        tick();
        check("post_rst_accept", {203'd0, out_valid}, 204'd1);
        check("post_rst_pc", {140'd0, out_pc}, {140'd0, 64'hC100});
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();

        // Random stalls with aluctr=0x1F, word_op=1
        k = 0;
        for (int c = 0; c < 300 && k < 20; c++) begin
            drive(1'b1, 64'hD000 + 64'(8 * k), 64'hFFFF_0000_0000 + 64'(k), 64'(k * 3),
                  5'h1F, 1'b1, 5'(k), k[0]);
            out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        check("stall_all_sent", 204'(k), 204'd20);
        drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("sb_drained", 204'(sb_q.size()), 204'd0);
        check("final_empty", {203'd0, out_valid}, 204'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
